// File: rtl/mac_pipe_sat.sv
// Pipelined signed multiply-accumulate with optional product register,
// saturating or wrapping accumulation, sticky overflow, restart and sample counter.
module mac_pipe_sat #(
    parameter int IN_W      = 8,
    parameter int ACC_W     = 16,
    parameter int PIPE_MULT = 0,
    parameter int SAT_EN    = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic             valid_in,
    input  logic             clear_acc,
    output logic [ACC_W-1:0] f,
    output logic             valid_out,
    output logic             overflow,
    output logic [CNT_W-1:0] count
);

    localparam int PW = 2 * IN_W;
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    if (ACC_W < 2 * IN_W) begin : g_bad_acc_w
        $error("mac_pipe_sat: ACC_W must be at least 2*IN_W");
    end
    if (PIPE_MULT != 0 && PIPE_MULT != 1) begin : g_bad_pipe
        $error("mac_pipe_sat: PIPE_MULT must be 0 or 1");
    end

    // Valid semantics: a sample is taken whenever valid_in is high on a rising
    // edge; there is no backpressure and each sample yields one valid_out pulse.
    logic [IN_W-1:0] a_q, b_q;
    logic            v0_q, c0_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            v0_q <= 1'b0;
            c0_q <= 1'b0;
        end else begin
            a_q  <= a;
            b_q  <= b;
            v0_q <= valid_in;
            c0_q <= clear_acc;
        end
    end

    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] p_acc;
    logic                 v_acc, c_acc;

    assign prod_d = PW'($signed(a_q)) * PW'($signed(b_q));

    if (PIPE_MULT == 1) begin : g_pipe
        logic signed [PW-1:0] p_q;
        logic                 v1_q, c1_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                p_q  <= '0;
                v1_q <= 1'b0;
                c1_q <= 1'b0;
            end else begin
                p_q  <= prod_d;
                v1_q <= v0_q;
                c1_q <= c0_q;
            end
        end

        assign p_acc = p_q;
        assign v_acc = v1_q;
        assign c_acc = c1_q;
    end else begin : g_nopipe
        assign p_acc = prod_d;
        assign v_acc = v0_q;
        assign c_acc = c0_q;
    end

    logic [ACC_W-1:0]        f_q, f_d;
    logic                    ov_q, ov_d;
    logic                    vout_q, vout_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W:0]   sum;
    logic                    sum_ovf;

    // One guard bit: the sum left the ACC_W range when the top two bits differ.
    assign p_ext   = ACC_W'(p_acc);
    assign sum     = (ACC_W+1)'($signed(f_q)) + (ACC_W+1)'(p_ext);
    assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];

    always_comb begin
        f_d    = f_q;
        ov_d   = ov_q;
        cnt_d  = cnt_q;
        vout_d = 1'b0;
        if (v_acc) begin
            vout_d = 1'b1;
            if (c_acc) begin
                f_d   = p_ext;
                ov_d  = 1'b0;
                cnt_d = CNT_W'(1);
            end else begin
                if (sum_ovf) begin
                    ov_d = 1'b1;
                    if (SAT_EN != 0) begin
                        f_d = sum[ACC_W] ? ACC_MIN : ACC_MAX;
                    end else begin
                        f_d = sum[ACC_W-1:0];
                    end
                end else begin
                    f_d = sum[ACC_W-1:0];
                end
                cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_q    <= '0;
            ov_q   <= 1'b0;
            vout_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            f_q    <= f_d;
            ov_q   <= ov_d;
            vout_q <= vout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign f         = f_q;
    assign overflow  = ov_q;
    assign valid_out = vout_q;
    assign count     = cnt_q;

endmodule

// File: tb/tb_mac_pipe_sat.sv
// Randomized and directed bench for mac_pipe_sat: three instances (saturating,
// wrapping, pipelined with a narrow counter) checked against an arithmetic model.
module tb_mac_pipe_sat;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] a, b;
    logic       valid_in, clear_acc;

    logic [15:0] f_w   [3];
    logic        vo_w  [3];
    logic        ov_w  [3];
    logic [7:0]  cnt_w [3];
    logic [7:0]  cnt0, cnt1;
    logic [2:0]  cnt2;

    always #5 clk = ~clk;

    mac_pipe_sat #(.IN_W(8), .ACC_W(16), .PIPE_MULT(0), .SAT_EN(1), .CNT_W(8)) u_sat (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
        .f(f_w[0]), .valid_out(vo_w[0]), .overflow(ov_w[0]), .count(cnt0));

    mac_pipe_sat #(.IN_W(8), .ACC_W(16), .PIPE_MULT(0), .SAT_EN(0), .CNT_W(8)) u_wrap (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
        .f(f_w[1]), .valid_out(vo_w[1]), .overflow(ov_w[1]), .count(cnt1));

    mac_pipe_sat #(.IN_W(8), .ACC_W(16), .PIPE_MULT(1), .SAT_EN(1), .CNT_W(3)) u_pipe (
        .clk(clk), .reset(reset), .a(a), .b(b), .valid_in(valid_in), .clear_acc(clear_acc),
        .f(f_w[2]), .valid_out(vo_w[2]), .overflow(ov_w[2]), .count(cnt2));

    assign cnt_w[0] = cnt0;
    assign cnt_w[1] = cnt1;
    assign cnt_w[2] = {5'b0, cnt2};

    int lat  [3] = '{1, 1, 2};
    int sat  [3] = '{1, 0, 1};
    int cntw [3] = '{8, 8, 3};

    // Model state after every sample issued so far (ahead of the DUT outputs).
    longint mf   [3];
    logic   mov  [3];
    int     mcnt [3];
    // Values the outputs should currently show.
    logic [15:0] cur_f   [3];
    logic        cur_ov  [3];
    logic [7:0]  cur_cnt [3];

    // Entry: {due_cycle[31:0], f[15:0], overflow, count[7:0]}
    logic [56:0] exp_q [3][$];

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            mf[i] = 0; mov[i] = 1'b0; mcnt[i] = 0;
            cur_f[i] = '0; cur_ov[i] = 1'b0; cur_cnt[i] = '0;
        end
    endfunction

    function automatic void model_sample(input logic [7:0] ta, input logic [7:0] tb_, input logic c);
        longint p, s, hi, lo;
        hi = 32767;
        lo = -32768;
        p = longint'($signed(ta)) * longint'($signed(tb_));
        for (int i = 0; i < 3; i++) begin
            if (c) begin
                mf[i] = p; mov[i] = 1'b0; mcnt[i] = 1;
            end else begin
                s = mf[i] + p;
                if (s > hi || s < lo) begin
                    mov[i] = 1'b1;
                    if (sat[i] != 0) s = (s > hi) ? hi : lo;
                    else if (s > hi) s = s - 65536;
                    else s = s + 65536;
                end
                mf[i] = s;
                if (mcnt[i] < (1 << cntw[i]) - 1) mcnt[i] = mcnt[i] + 1;
            end
            exp_q[i].push_back({32'(cyc + 1 + lat[i]), 16'(mf[i]), mov[i], 8'(mcnt[i])});
        end
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) model_reset();
    end

    always @(negedge clk) begin
        logic [56:0] e;
        for (int i = 0; i < 3; i++) begin
            if (exp_q[i].size() > 0 && int'(exp_q[i][0][56:25]) == cyc) begin
                e = exp_q[i].pop_front();
                cur_f[i] = e[24:9]; cur_ov[i] = e[8]; cur_cnt[i] = e[7:0];
                check($sformatf("u%0d_valid", i), 64'(vo_w[i]), 64'(1));
            end else begin
                check($sformatf("u%0d_valid", i), 64'(vo_w[i]), 64'(0));
            end
            check($sformatf("u%0d_f", i), 64'(f_w[i]), 64'(cur_f[i]));
            check($sformatf("u%0d_ovf", i), 64'(ov_w[i]), 64'(cur_ov[i]));
            check($sformatf("u%0d_count", i), 64'(cnt_w[i]), 64'(cur_cnt[i]));
        end
    end

    task automatic step(input logic [7:0] ta, input logic [7:0] tb_, input logic v,
                        input logic c, input logic r);
        a = ta; b = tb_; valid_in = v; clear_acc = c; reset = r;
        if (v && !r) model_sample(ta, tb_, c);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        step(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        step(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();
        reset = 1'b1; a = '0; b = '0; valid_in = 1'b0; clear_acc = 1'b0;
        @(posedge clk); #1;
        do_reset();
        check("reset_f", 64'(f_w[0]), 64'(0));
        check("reset_count", 64'(cnt_w[2]), 64'(0));

        // Basic stream with bubbles.
        step(8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
        step(8'd2, 8'd2, 1'b1, 1'b0, 1'b0);
        step(8'd3, 8'd3, 1'b1, 1'b0, 1'b0);
        idle(2);
        step(8'd6, 8'd6, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("basic_f", 64'(f_w[0]), 64'd49);
        check("basic_count", 64'(cnt_w[0]), 64'd3);
        check("basic_pipe_f", 64'(f_w[2]), 64'd49);

        // Positive saturation, then restart with clear_acc.
        do_reset();
        for (int k = 0; k < 3; k++) step(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("sat_pos_f", 64'(f_w[0]), 64'(16'h7FFF));
        check("sat_pos_ovf", 64'(ov_w[0]), 64'd1);
        check("wrap_3x_f", 64'(f_w[1]), 64'(16'hC000));
        step(8'd127, 8'h80, 1'b1, 1'b1, 1'b0);
        idle(3);
        check("clear_f", 64'(f_w[0]), 64'(16'hC080));
        check("clear_ovf", 64'(ov_w[0]), 64'd0);
        check("clear_count", 64'(cnt_w[0]), 64'd1);

        // Wrap keeps overflow sticky across a later in-range sum.
        do_reset();
        step(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        step(8'h80, 8'h80, 1'b1, 1'b0, 1'b0);
        step(8'd1, 8'd1, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("wrap_f", 64'(f_w[1]), 64'(16'h8001));
        check("wrap_ovf", 64'(ov_w[1]), 64'd1);

        // Negative saturation.
        do_reset();
        for (int k = 0; k < 3; k++) step(8'd127, 8'h80, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("sat_neg_f", 64'(f_w[0]), 64'(16'h8000));
        check("sat_neg_ovf", 64'(ov_w[0]), 64'd1);

        // Reset with samples in flight, then a fresh sample.
        step(8'd3, 8'd3, 1'b1, 1'b0, 1'b0);
        step(8'd4, 8'd4, 1'b1, 1'b0, 1'b0);
        step(8'd0, 8'd0, 1'b0, 1'b0, 1'b1);
        check("midreset_f", 64'(f_w[2]), 64'd0);
        step(8'd5, 8'd5, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("post_reset_f", 64'(f_w[2]), 64'd25);
        check("post_reset_count", 64'(cnt_w[2]), 64'd1);

        // Random traffic: bubbles, restarts, occasional reset, extreme operands.
        for (int k = 0; k < 600; k++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) != 0) ? 8'h80 : 8'h7F;
            step(ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 99) == 0);
        end
        idle(4);
        for (int i = 0; i < 3; i++) check($sformatf("u%0d_drained", i), 64'(exp_q[i].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
